gb_mem_region: RTL and testbench

Parametrised dual-port memory region for the Game Boy memory map, generalising the fixed per-region BRAM wrappers (VRAM, OAM, HRAM, WRAM) into one block. It provides a CPU read/write port with PPU-mode access lockout, a never-locked PPU read port, and a built-in byte-copy DMA engine. The DMA engine serves the FF46 OAM DMA and any future block-copy use. It sits between the CPU address decoder and the PPU, one instance per region.

---
 rtl/gb_mem_region.sv | 150 +++++++++++++++
 tb/tb_gb_mem_region.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_mem_region.sv
// gb_mem_region
//   One Game Boy memory region (VRAM/OAM/HRAM/WRAM style) built on a
//   true-dual-port RAM with read-first behaviour. It also contains a
//   byte-copy DMA engine.
//   Port A is shared by the CPU and the DMA engine; the DMA always wins.
//   Port B is the PPU port. It is read-only and never locked.
//
// Ports
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   cpu_addr/wdata/we   : CPU access; blocked by cpu_lock, DMA activity or
//                         an address beyond DEPTH
//   cpu_rdata           : registered CPU read data (LOCK_VALUE when blocked)
//   cpu_lock            : PPU-mode lockout request
//   ppu_addr/ppu_rdata  : PPU read port, registered, 1 clk latency
//   dma_start/dma_page  : start pulse and source page of a block copy
//   dma_tick            : M-cycle strobe; each tick fetches one source byte
//   dma_src_addr        : registered source address {page, idx}
//   dma_src_rdata       : source byte, valid in the cycle after dma_src_addr
//   dma_busy            : copy in progress
module gb_mem_region #(
  parameter int unsigned       ADDR_W     = 13,
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       DEPTH      = 2**ADDR_W,
  parameter logic [DATA_W-1:0] LOCK_VALUE = DATA_W'(8'hFF),
  parameter int unsigned       DMA_LEN    = 160,
  parameter string             INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic [DATA_W-1:0] ppu_rdata,
  input  logic              dma_start,
  input  logic [7:0]        dma_page,
  input  logic              dma_tick,
  output logic [15:0]       dma_src_addr,
  input  logic [DATA_W-1:0] dma_src_rdata,
  output logic              dma_busy
);

  localparam int unsigned     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]      LAST_IDX = 8'(DMA_LEN - 1);

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_FETCH,
    DMA_WRITE
  } dma_state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  dma_state_e        state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        page_q, page_d;
  logic [15:0]       src_q, src_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ppu_rdata_q, ppu_rdata_d;

  logic              cpu_in_range, ppu_in_range, cpu_ok;
  logic              dma_we, a_we;
  logic [IDX_W-1:0]  a_addr;
  logic [DATA_W-1:0] a_wdata;

  assign cpu_in_range = ({1'b0, cpu_addr} < DEPTH_L);
  assign ppu_in_range = ({1'b0, ppu_addr} < DEPTH_L);
  assign cpu_ok       = !cpu_lock && !busy_q && cpu_in_range;

  // A start pulse during WRITE restarts the copy, so it also cancels that
  // cycle's write.
  assign dma_we  = (state_q == DMA_WRITE) && !dma_start;
  assign a_we    = dma_we || (cpu_ok && cpu_we);
  assign a_addr  = dma_we ? IDX_W'(idx_q) : IDX_W'(cpu_addr);
  assign a_wdata = dma_we ? dma_src_rdata : cpu_wdata;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    page_d  = page_q;
    src_d   = src_q;
    if (dma_start) begin
      idx_d   = '0;
      page_d  = dma_page;
      state_d = DMA_FETCH;
    end else begin
      unique case (state_q)
        DMA_FETCH: begin
          if (dma_tick) begin
            src_d   = {page_q, idx_q};
            state_d = DMA_WRITE;
          end
        end
        DMA_WRITE: begin
          if (idx_q == LAST_IDX) begin
            state_d = DMA_IDLE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = DMA_FETCH;
          end
        end
        default: state_d = DMA_IDLE;
      endcase
    end
    busy_d = (state_d != DMA_IDLE);
  end

  // Combinational reads of the array give read-first data on both ports.
  always_comb begin
    cpu_rdata_d = cpu_ok       ? mem[IDX_W'(cpu_addr)] : LOCK_VALUE;
    ppu_rdata_d = ppu_in_range ? mem[IDX_W'(ppu_addr)] : LOCK_VALUE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DMA_IDLE;
      idx_q       <= '0;
      page_q      <= '0;
      src_q       <= '0;
      busy_q      <= 1'b0;
      cpu_rdata_q <= '0;
      ppu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      page_q      <= page_d;
      src_q       <= src_d;
      busy_q      <= busy_d;
      cpu_rdata_q <= cpu_rdata_d;
      ppu_rdata_q <= ppu_rdata_d;
    end
  end

  // The RAM contents are not reset.
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem[a_addr] <= a_wdata;
    end
  end

  assign cpu_rdata    = cpu_rdata_q;
  assign ppu_rdata    = ppu_rdata_q;
  assign dma_src_addr = src_q;
  assign dma_busy     = busy_q;

endmodule

// File: tb/tb_gb_mem_region.sv
// tb_gb_mem_region
//   Scoreboard bench for gb_mem_region. Expected read data comes from a
//   model memory and the lockout rules. It is queued when the stimulus is
//   driven and popped by a monitor one clk later, when the DUT outputs it.
//   A second instance with DEPTH=127 covers the out-of-range case.
module tb_gb_mem_region;

  localparam int unsigned DMA_LEN = 160;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [7:0]  cpu_rdata;
  logic        cpu_lock;
  logic [12:0] ppu_addr;
  logic [7:0]  ppu_rdata;
  logic        dma_start;
  logic [7:0]  dma_page;
  logic        dma_tick;
  logic [15:0] dma_src_addr;
  logic [7:0]  dma_src_rdata;
  logic        dma_busy;

  logic [6:0]  s_cpu_addr;
  logic [7:0]  s_cpu_wdata;
  logic        s_cpu_we;
  logic [7:0]  s_cpu_rdata;
  logic [6:0]  s_ppu_addr;
  logic [7:0]  s_ppu_rdata;
  logic [15:0] s_src_addr;
  logic        s_busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  sb_t cpu_q[$];
  sb_t ppu_q[$];
  sb_t src_q[$];
  sb_t s_q[$];

  logic [7:0] model [8192];
  logic       lock_req   = 1'b0;
  logic       dma_active = 1'b0;

  always #5 clk = ~clk;

  // Source memory: the low address byte ^ A5, perturbed by the page so that
  // copies from different pages leave different RAM images.
  function automatic logic [7:0] src_fn(input logic [15:0] a);
    return a[7:0] ^ 8'hA5 ^ a[15:8] ^ 8'hC1;
  endfunction

  assign dma_src_rdata = src_fn(dma_src_addr);

  gb_mem_region u_dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_we       (cpu_we),
    .cpu_rdata    (cpu_rdata),
    .cpu_lock     (cpu_lock),
    .ppu_addr     (ppu_addr),
    .ppu_rdata    (ppu_rdata),
    .dma_start    (dma_start),
    .dma_page     (dma_page),
    .dma_tick     (dma_tick),
    .dma_src_addr (dma_src_addr),
    .dma_src_rdata(dma_src_rdata),
    .dma_busy     (dma_busy)
  );

  gb_mem_region #(
    .ADDR_W (7),
    .DEPTH  (127),
    .DMA_LEN(100)
  ) u_small (
    .clk          (clk),
    .rst          (rst),
    .cpu_addr     (s_cpu_addr),
    .cpu_wdata    (s_cpu_wdata),
    .cpu_we       (s_cpu_we),
    .cpu_rdata    (s_cpu_rdata),
    .cpu_lock     (1'b0),
    .ppu_addr     (s_ppu_addr),
    .ppu_rdata    (s_ppu_rdata),
    .dma_start    (1'b0),
    .dma_page     (8'h00),
    .dma_tick     (1'b0),
    .dma_src_addr (s_src_addr),
    .dma_src_rdata(8'h00),
    .dma_busy     (s_busy)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of CPU/PPU stimulus and queue the expected read data.
  task automatic set_io(input logic [12:0] a, input logic we, input logic [7:0] d,
                        input bit cchk, input logic [12:0] pa, input bit pchk,
                        input string tag);
    sb_t  e;
    logic blk;
    blk       = lock_req | dma_active;
    cpu_lock  = lock_req;
    cpu_addr  = a;
    cpu_we    = we;
    cpu_wdata = d;
    ppu_addr  = pa;
    if (cchk) begin
      e.tag = tag;
      e.exp = {8'h00, blk ? 8'hFF : model[a]};
      cpu_q.push_back(e);
    end
    if (pchk) begin
      e.tag = {tag, "_ppu"};
      e.exp = {8'h00, model[pa]};
      ppu_q.push_back(e);
    end
    if (!blk && we) model[a] = d;
  endtask

  task automatic drive(input logic [12:0] a, input logic we, input logic [7:0] d,
                       input bit cchk, input logic [12:0] pa, input bit pchk,
                       input string tag);
    @(negedge clk);
    set_io(a, we, d, cchk, pa, pchk, tag);
  endtask

  task automatic idle();
    drive(13'h0, 1'b0, 8'h00, 0, 13'h0, 0, "");
  endtask

  task automatic s_drive(input logic [6:0] a, input logic we, input logic [7:0] d,
                         input bit chk, input logic [7:0] exp_c, input logic [7:0] exp_p,
                         input string tag);
    sb_t e;
    @(negedge clk);
    s_cpu_addr  = a;
    s_cpu_we    = we;
    s_cpu_wdata = d;
    s_ppu_addr  = a;
    if (chk) begin
      e.tag = tag;
      e.exp = {exp_c, exp_p};
      s_q.push_back(e);
    end
  endtask

  // Run a DMA copy with a tick every 4 clks, aligned so the first tick is
  // sampled 3 clks after the start edge. In this way, busy lasts exactly 4*DMA_LEN clks.
  // restart_c > 0 re-pulses dma_start with rpage at that cycle, and abort_c > 0
  // asserts rst mid-cycle at that point.
  task automatic run_dma(input logic [7:0] page, input int restart_c, input logic [7:0] rpage,
                         input int abort_c, input string tag);
    sb_t        e;
    int         c;
    int         bcnt;
    int         idx;
    int         guard;
    int         rs_c;
    bit         done;
    logic [7:0] cur;
    @(negedge clk);
    set_io(13'h0, 1'b0, 8'h00, 0, 13'h0, 0, "");
    dma_page  = page;
    dma_start = 1'b1;
    cur       = page;
    @(negedge clk);
    dma_start  = 1'b0;
    dma_active = 1'b1;
    c = 0; bcnt = 0; idx = 0; guard = 0; done = 0; rs_c = restart_c;
    while (!done) begin
      if (dma_start) begin
        dma_start = 1'b0;
        c = 0; bcnt = 0; idx = 0;
        cur = rpage;
      end
      if (abort_c > 0 && c == abort_c) begin
        dma_tick = 1'b0;
        set_io(13'h0, 1'b0, 8'h00, 0, 13'h0, 0, "");
        #3;
        rst = 1'b1;
        #1;
        check({tag, "_busy_rst"},  16'(dma_busy), 16'h0);
        check({tag, "_cpu_rst"},   16'(cpu_rdata), 16'h0);
        check({tag, "_ppu_rst"},   16'(ppu_rdata), 16'h0);
        check({tag, "_src_rst"},   dma_src_addr, 16'h0);
        done = 1;
      end else if (!dma_busy) begin
        done = 1;
      end else begin
        bcnt++;
        dma_tick = (c % 4 == 2);
        if (dma_tick) begin
          e.tag = $sformatf("%s_src%0d", tag, idx);
          e.exp = {cur, 8'(idx)};
          src_q.push_back(e);
          idx++;
        end
        if (rs_c > 0 && c == rs_c) begin
          dma_start = 1'b1;
          dma_page  = rpage;
          rs_c      = 0;
        end
        // CPU accesses mid-transfer target bytes that were already copied.
        if (c % 64 == 20)
          set_io(13'(c / 16), (c % 128 == 20), 8'h00, 1, 13'h0, 0, {tag, "_cpu_blk"});
        else
          set_io(13'h0, 1'b0, 8'h00, 0, 13'h0, 0, "");
        @(negedge clk);
        c++;
        guard++;
        if (guard > 4000) begin
          check({tag, "_timeout"}, 16'h1, 16'h0);
          done = 1;
        end
      end
    end
    dma_tick   = 1'b0;
    dma_active = 1'b0;
    if (abort_c == 0) check({tag, "_busy_clks"}, 16'(bcnt), 16'(4 * DMA_LEN));
  endtask

  // Monitor: pops one expectation per stream after each edge.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (cpu_q.size() > 0) begin e = cpu_q.pop_front(); check(e.tag, 16'(cpu_rdata), e.exp); end
        if (ppu_q.size() > 0) begin e = ppu_q.pop_front(); check(e.tag, 16'(ppu_rdata), e.exp); end
        if (src_q.size() > 0) begin e = src_q.pop_front(); check(e.tag, dma_src_addr, e.exp); end
        if (s_q.size() > 0)   begin e = s_q.pop_front();   check(e.tag, {s_cpu_rdata, s_ppu_rdata}, e.exp); end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_lock = 1'b0; ppu_addr = '0;
    dma_start = 1'b0; dma_page = '0; dma_tick = 1'b0;
    s_cpu_addr = '0; s_cpu_wdata = '0; s_cpu_we = 1'b0; s_ppu_addr = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_rdata", 16'(cpu_rdata), 16'h0);
    check("rst_ppu_rdata", 16'(ppu_rdata), 16'h0);
    check("rst_src_addr",  dma_src_addr,   16'h0);
    check("rst_busy",      16'(dma_busy),  16'h0);
    check("rst_s_src",     s_src_addr,     16'h0);
    check("rst_s_busy",    16'(s_busy),    16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic access and readback of a small pattern.
    drive(13'h0010, 1'b1, 8'h5A, 0, 13'h0, 0, "");
    drive(13'h0010, 1'b0, 8'h00, 1, 13'h0, 0, "basic_rd");
    for (int unsigned i = 0; i < 8; i++)
      drive(13'(32'h20 + i), 1'b1, 8'(8'h30 + i * 7), 0, 13'h0, 0, "");
    for (int unsigned i = 0; i < 8; i++)
      drive(13'(32'h20 + i), 1'b0, 8'h00, 1, 13'(32'h20 + i), 1, $sformatf("pat_rd%0d", i));

    // Read-first: a read during a write returns the old byte.
    drive(13'h0020, 1'b1, 8'hEE, 1, 13'h0, 0, "cpu_rd_first");
    drive(13'h0020, 1'b0, 8'h00, 1, 13'h0, 0, "cpu_rd_new");
    drive(13'h0021, 1'b1, 8'h77, 0, 13'h0021, 1, "ppu_rd_first");
    drive(13'h0000, 1'b0, 8'h00, 0, 13'h0021, 1, "ppu_rd_new");

    // Lockout: the write is dropped and reads return FF, while the PPU still sees data.
    lock_req = 1'b1;
    drive(13'h0010, 1'b1, 8'h11, 1, 13'h0, 0, "lock_wr");
    drive(13'h0010, 1'b0, 8'h00, 1, 13'h0010, 1, "lock_rd");
    lock_req = 1'b0;
    drive(13'h0010, 1'b0, 8'h00, 1, 13'h0, 0, "unlock_rd");
    idle();

    // Full copy from page C1.
    run_dma(8'hC1, 0, 8'h00, 0, "dma1");
    for (int unsigned i = 0; i < DMA_LEN; i++) model[i] = src_fn({8'hC1, 8'(i)});
    for (int unsigned i = 0; i < DMA_LEN; i++)
      drive(13'(i), 1'b0, 8'h00, (i % 16 == 5), 13'(i), 1, $sformatf("dma1_ram%0d", i));
    drive(13'h00A0, 1'b0, 8'h00, 1, 13'h00A0, 0, "dma1_beyond");

    // Restart at idx 50 with page D0.
    run_dma(8'hC8, 200, 8'hD0, 0, "dma_rs");
    for (int unsigned i = 0; i < DMA_LEN; i++) model[i] = src_fn({8'hD0, 8'(i)});
    for (int unsigned i = 0; i < DMA_LEN; i++)
      drive(13'h0, 1'b0, 8'h00, 0, 13'(i), 1, $sformatf("dma_rs_ram%0d", i));

    // Reset mid-copy: idx 0..6 have been written by cycle 28.
    run_dma(8'hE2, 0, 8'h00, 28, "dma_ab");
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned i = 0; i < 7; i++) model[i] = src_fn({8'hE2, 8'(i)});
    for (int unsigned i = 0; i < 12; i++)
      drive(13'h0, 1'b0, 8'h00, 0, 13'(i), 1, $sformatf("dma_ab_ram%0d", i));
    idle();
    check("dma_ab_busy_after", 16'(dma_busy), 16'h0);

    // Small instance: DEPTH=127, so address 127 is out of range.
    s_drive(7'd126, 1'b1, 8'h44, 0, 8'h00, 8'h00, "");
    s_drive(7'd127, 1'b1, 8'h33, 0, 8'h00, 8'h00, "");
    s_drive(7'd127, 1'b0, 8'h00, 1, 8'hFF, 8'hFF, "s_oor_rd");
    s_drive(7'd126, 1'b0, 8'h00, 1, 8'h44, 8'h44, "s_in_rd");
    s_drive(7'd0,   1'b0, 8'h00, 0, 8'h00, 8'h00, "");

    repeat (3) idle();
    check("sb_drain", 16'(cpu_q.size() + ppu_q.size() + src_q.size() + s_q.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
